// File: rtl/rv32_mem_pkg.sv
// rv32_mem_pkg: size codes, FSM states and access-legality helpers for the data memory LSU
package rv32_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    // funct3[1:0] carries the access size for every legal code
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        return (funct3[1:0] == 2'b01 && addr_lo[0]) || (funct3[1:0] == 2'b10 && addr_lo != 2'b00);
    endfunction

    function automatic logic is_legal(input logic [2:0] funct3, input logic we);
        return we ? (funct3 == F3_B || funct3 == F3_H || funct3 == F3_W)
                  : (funct3 == F3_B || funct3 == F3_H || funct3 == F3_W || funct3 == F3_BU || funct3 == F3_HU);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane store merge and sign/zero-extending load extraction
//   i_funct3      : RV32I size code
//   i_addr_lo     : byte offset within the word
//   i_wdata       : right-aligned store data
//   i_old_word    : current array word
//   o_merged_word : old word with the store lanes replaced
//   o_load_result : extracted and extended load value
module mem_lane_align
    import rv32_mem_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_old_word,
    output logic [31:0] o_merged_word,
    output logic [31:0] o_load_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_old_word[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_old_word[{i_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        o_merged_word = i_old_word;
        if (i_funct3[1:0] == 2'b00)
            o_merged_word[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
        else if (i_funct3[1:0] == 2'b01)
            o_merged_word[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
        else
            o_merged_word = i_wdata;
    end

    assign o_load_result = (i_funct3 == F3_B)  ? {{24{w_byte[7]}}, w_byte} :
                           (i_funct3 == F3_H)  ? {{16{w_half[15]}}, w_half} :
                           (i_funct3 == F3_BU) ? {24'b0, w_byte} :
                           (i_funct3 == F3_HU) ? {16'b0, w_half} : i_old_word;

endmodule

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: parametrised RV32I data memory with load/store unit and wait states
//   i_clk, i_rst_n : clock, async active-low reset
//   i_req, i_we    : access request (sampled in IDLE), 1 = store
//   i_funct3       : size code, i_addr byte address, i_wdata store data
//   o_busy         : not IDLE
//   o_done, o_err  : completion pulse and error flag
//   o_rdata        : extended load result, held until next done
module data_mem_lsu
    import rv32_mem_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
)
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_rdata
);

    localparam int AW = $clog2(DEPTH);

    state_t      r_state;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [AW+1:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_cnt;
    logic        r_done;
    logic        r_err;
    logic [31:0] r_rdata;
    logic [31:0] r_mem [DEPTH-1:0];

    logic        w_idle;
    logic        w_we;
    logic [2:0]  w_funct3;
    logic [AW+1:0] w_addr;
    logic [31:0] w_old;
    logic [31:0] w_merged;
    logic [31:0] w_load;
    logic        w_bad;
    logic        w_go_resp;
    logic        w_unused;

    // In IDLE the live inputs describe the access; afterwards the latched copy does
    assign w_idle   = r_state == ST_IDLE;
    assign w_we     = w_idle ? i_we : r_we;
    assign w_funct3 = w_idle ? i_funct3 : r_funct3;
    assign w_addr   = w_idle ? i_addr[AW+1:0] : r_addr;
    assign w_old    = r_mem[w_addr[AW+1:2]];
    assign w_bad    = is_misaligned(w_funct3, w_addr[1:0]) || !is_legal(w_funct3, w_we);
    assign w_unused = ^i_addr[31:AW+2];

    // done/err/rdata are registered on the edge that enters RESP
    assign w_go_resp = (w_idle && i_req && (w_bad || WAIT_STATES == 0)) ||
                       (r_state == ST_WAIT && r_cnt == 4'd0);

    mem_lane_align u_align (
        .i_funct3      (w_funct3),
        .i_addr_lo     (w_addr[1:0]),
        .i_wdata       (r_wdata),
        .i_old_word    (w_old),
        .o_merged_word (w_merged),
        .o_load_result (w_load)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_we     <= 1'b0;
            r_funct3 <= 3'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_cnt    <= 4'd0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_done <= w_go_resp;
            r_err  <= w_go_resp && w_bad;
            if (w_go_resp)
                r_rdata <= w_bad ? '0 : (w_we ? r_rdata : w_load);
            case (r_state)
                ST_IDLE: if (i_req) begin
                    r_we     <= i_we;
                    r_funct3 <= i_funct3;
                    r_addr   <= i_addr[AW+1:0];
                    r_wdata  <= i_wdata;
                    r_cnt    <= 4'(WAIT_STATES - 1);
                    r_state  <= w_go_resp ? ST_RESP : ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0)
                        r_state <= ST_RESP;
                    else
                        r_cnt <= r_cnt - 4'd1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Reset forces IDLE asynchronously, so a store pending in RESP never commits
    always_ff @(posedge i_clk) begin
        if (r_state == ST_RESP && r_we && !r_err)
            r_mem[r_addr[AW+1:2]] <= w_merged;
    end

    assign o_busy  = !w_idle;
    assign o_done  = r_done;
    assign o_err   = r_err;
    assign o_rdata = r_rdata;

endmodule

// File: tb/tb_data_mem_lsu.sv
// tb_data_mem_lsu: scoreboard bench over three LSU instances (0, 3 and 2 wait states)
module tb_data_mem_lsu;
    import rv32_mem_pkg::*;

    typedef struct {
        int          dut;
        logic        err;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic [2:0]  rst_n;
    logic [2:0]  req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  busy;
    logic [2:0]  done;
    logic [2:0]  err;
    logic [31:0] rdata [3];

    exp_t        q[$];
    logic [31:0] prev [3];
    int          cyc = 0;
    int          checks = 0;
    int          fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_lsu #(.DEPTH(64), .WAIT_STATES(0)) u0 (
        .i_clk(clk), .i_rst_n(rst_n[0]), .i_req(req[0]), .i_we(we), .i_funct3(funct3),
        .i_addr(addr), .i_wdata(wdata), .o_busy(busy[0]), .o_done(done[0]), .o_err(err[0]), .o_rdata(rdata[0]));
    data_mem_lsu #(.DEPTH(64), .WAIT_STATES(3)) u1 (
        .i_clk(clk), .i_rst_n(rst_n[1]), .i_req(req[1]), .i_we(we), .i_funct3(funct3),
        .i_addr(addr), .i_wdata(wdata), .o_busy(busy[1]), .o_done(done[1]), .o_err(err[1]), .o_rdata(rdata[1]));
    data_mem_lsu #(.DEPTH(64), .WAIT_STATES(2)) u2 (
        .i_clk(clk), .i_rst_n(rst_n[2]), .i_req(req[2]), .i_we(we), .i_funct3(funct3),
        .i_addr(addr), .i_wdata(wdata), .o_busy(busy[2]), .o_done(done[2]), .o_err(err[2]), .o_rdata(rdata[2]));

    function automatic int ws_of(input int k);
        return k == 1 ? 3 : (k == 2 ? 2 : 0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected response
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (done[k]) begin
                if (q.size() == 0 || q[0].dut != k) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_done dut=%0d cycle=%0d", k, cyc);
                end else begin
                    exp_t x;
                    x = q.pop_front();
                    chk($sformatf("err dut%0d", k), {31'b0, err[k]}, {31'b0, x.err});
                    chk($sformatf("rdata dut%0d", k), rdata[k], x.rdata);
                    chk($sformatf("latency dut%0d", k), cyc, x.due);
                end
            end
        end
    end

    // Issue one access; expected response is queued before the DUT can answer
    task automatic access(input int k, input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input logic e, input logic [31:0] rd, input bit pulse);
        exp_t x;
        int   nb;
        bit   ok;
        @(negedge clk);
        we = w; funct3 = f3; addr = a; wdata = d; req[k] = 1'b1;
        x.dut   = k;
        x.err   = e;
        x.rdata = e ? 32'h0 : (w ? prev[k] : rd);
        x.due   = cyc + 1 + (e ? 0 : ws_of(k));
        q.push_back(x);
        prev[k] = x.rdata;
        @(posedge clk);
        #1;
        req[k] = 1'b0;
        we = ~w; funct3 = 3'b011; addr = ~a; wdata = ~d;
        nb = 0;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy[k]) begin
                ok = 1;
                break;
            end
            nb++;
            req[k] = pulse && nb == 2;
        end
        req[k] = 1'b0;
        if (!ok) begin
            checks++;
            fails++;
            $display("FAIL timeout dut=%0d addr=%h", k, a);
        end else
            chk($sformatf("busy_cycles dut%0d", k), nb, e ? 1 : ws_of(k) + 1);
        if (pulse) repeat (8) @(negedge clk);
    endtask

    // Store over 0x20 interrupted by reset `edges` cycles after entering WAIT
    task automatic store_reset(input int k, input int edges);
        @(negedge clk);
        we = 1'b1; funct3 = F3_W; addr = 32'h20; wdata = 32'hAAAAAAAA; req[k] = 1'b1;
        @(posedge clk);
        #1;
        req[k] = 1'b0;
        repeat (edges) @(posedge clk);
        #1;
        rst_n[k] = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'b0, busy[k]}, 32'h0);
        chk("rst_done", {31'b0, done[k]}, 32'h0);
        chk("rst_err", {31'b0, err[k]}, 32'h0);
        chk("rst_rdata", rdata[k], 32'h0);
        @(negedge clk);
        rst_n[k] = 1'b1;
        prev[k] = 32'h0;
    endtask

    initial begin
        rst_n = 3'b000; req = 3'b000; we = 1'b0; funct3 = F3_W; addr = '0; wdata = '0;
        for (int k = 0; k < 3; k++) prev[k] = 32'h0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_busy dut%0d", k), {31'b0, busy[k]}, 32'h0);
            chk($sformatf("reset_done dut%0d", k), {31'b0, done[k]}, 32'h0);
            chk($sformatf("reset_err dut%0d", k), {31'b0, err[k]}, 32'h0);
            chk($sformatf("reset_rdata dut%0d", k), rdata[k], 32'h0);
        end
        rst_n = 3'b111;

        // zero wait states: merge, extension, misalignment, illegal codes, wrap
        access(0, 1, F3_W,  32'h10,  32'hDEADBEEF, 0, 0, 0);
        access(0, 0, F3_W,  32'h10,  0, 0, 32'hDEADBEEF, 0);
        access(0, 1, F3_B,  32'h11,  32'hFFFFFF80, 0, 0, 0);
        access(0, 0, F3_W,  32'h10,  0, 0, 32'hDEAD80EF, 0);
        access(0, 0, F3_B,  32'h11,  0, 0, 32'hFFFFFF80, 0);
        access(0, 0, F3_BU, 32'h11,  0, 0, 32'h00000080, 0);
        access(0, 1, F3_H,  32'h12,  32'h12347FFF, 0, 0, 0);
        access(0, 0, F3_W,  32'h10,  0, 0, 32'h7FFF80EF, 0);
        access(0, 0, F3_H,  32'h12,  0, 0, 32'h00007FFF, 0);
        access(0, 0, F3_H,  32'h10,  0, 0, 32'hFFFF80EF, 0);
        access(0, 0, F3_HU, 32'h10,  0, 0, 32'h000080EF, 0);
        access(0, 0, F3_B,  32'h13,  0, 0, 32'h0000007F, 0);
        access(0, 0, F3_B,  32'h10,  0, 0, 32'hFFFFFFEF, 0);
        access(0, 0, F3_W,  32'h12,  0, 1, 0, 0);
        access(0, 1, F3_H,  32'h13,  32'h0000AAAA, 1, 0, 0);
        access(0, 0, F3_W,  32'h10,  0, 0, 32'h7FFF80EF, 0);
        access(0, 0, 3'b011, 32'h10, 0, 1, 0, 0);
        access(0, 0, 3'b110, 32'h10, 0, 1, 0, 0);
        access(0, 1, F3_BU, 32'h10,  32'h00000011, 1, 0, 0);
        access(0, 0, F3_W,  32'h10,  0, 0, 32'h7FFF80EF, 0);
        access(0, 1, F3_W,  32'h100, 32'h12345678, 0, 0, 0);
        access(0, 0, F3_W,  32'h000, 0, 0, 32'h12345678, 0);

        // three wait states, including a request pulsed mid-access
        access(1, 1, F3_W,  32'h40,  32'hCAFEF00D, 0, 0, 0);
        access(1, 0, F3_W,  32'h40,  0, 0, 32'hCAFEF00D, 1);
        access(1, 0, F3_W,  32'h41,  0, 1, 0, 0);
        access(1, 0, F3_H,  32'h42,  0, 0, 32'hFFFFCAFE, 0);

        // two wait states, reset dropping a pending store in WAIT and in RESP
        access(2, 1, F3_W,  32'h20,  32'h55555555, 0, 0, 0);
        access(2, 0, F3_W,  32'h20,  0, 0, 32'h55555555, 0);
        store_reset(2, 0);
        access(2, 0, F3_W,  32'h20,  0, 0, 32'h55555555, 0);
        store_reset(2, 2);
        access(2, 0, F3_W,  32'h20,  0, 0, 32'h55555555, 0);

        repeat (5) @(negedge clk);
        chk("pending_responses", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
